// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - multi-lane saturating partial-sum accumulator with valid/ready result
module psum_accumulator #(
  parameter int LANES = 16,
  parameter int LEN_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [LEN_W-1:0]      acc_len_i,
  input  logic                  prod_valid_i,
  input  logic [32*LANES-1:0]   prod_i,
  output logic                  sum_valid_o,
  input  logic                  sum_ready_i,
  output logic [32*LANES-1:0]   sum_o,
  output logic                  busy_o,
  output logic [LANES-1:0]      ovf_o,
  output logic                  drop_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t              state_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [32*LANES-1:0] acc_q;
  logic [32*LANES-1:0] acc_d;
  logic [LANES-1:0]    ovf_q;
  logic [LANES-1:0]    clamp_d;
  logic                drop_q;
  logic                sum_valid_q;
  logic                busy_q;
  logic                last_beat;
  logic [32:0]         lane_sum;

  // The beat that brings the count up to the latched length closes the pass.
  assign last_beat = (cnt_q == (len_q - LEN_ONE));

  // Per-lane 33-bit signed add of the held sum and the incoming product, clamped to 32 bits.
  always_comb begin
    acc_d    = acc_q;
    clamp_d  = '0;
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = {acc_q[32*k+31], acc_q[32*k +: 32]} + {prod_i[32*k+31], prod_i[32*k +: 32]};
      if (lane_sum[32] != lane_sum[31]) begin
        // Sign bit disagrees with bit 31: the true result left the 32-bit range.
        clamp_d[k]       = 1'b1;
        acc_d[32*k +: 32] = lane_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        acc_d[32*k +: 32] = lane_sum[31:0];
      end
    end
  end

  // Pass control: IDLE waits for a non-zero start, ACC sums beats, OUT holds the result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= '0;
      drop_q      <= 1'b0;
      sum_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (prod_valid_i) begin
            drop_q <= 1'b1;
          end
          // A start in the same cycle as a stray beat wins: the new pass begins with clean flags.
          if (start_i && (acc_len_i != '0)) begin
            len_q   <= acc_len_i;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= '0;
            drop_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ACC;
          end
        end
        ACC: begin
          if (prod_valid_i) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | clamp_d;
            cnt_q <= cnt_q + LEN_ONE;
            if (last_beat) begin
              sum_valid_q <= 1'b1;
              state_q     <= OUT;
            end
          end
        end
        OUT: begin
          if (prod_valid_i) begin
            drop_q <= 1'b1;
          end
          if (sum_ready_i) begin
            sum_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          sum_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign sum_valid_o = sum_valid_q;
  assign sum_o       = acc_q;
  assign busy_o      = busy_q;
  assign ovf_o       = ovf_q;
  assign drop_o      = drop_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - self-checking bench for psum_accumulator
module tb_psum_accumulator;

  localparam int LANES = 16;
  localparam int LEN_W = 12;

  logic                  clk;
  logic                  rst_n;
  logic                  start_i;
  logic [LEN_W-1:0]      acc_len_i;
  logic                  prod_valid_i;
  logic [32*LANES-1:0]   prod_i;
  logic                  sum_valid_o;
  logic                  sum_ready_i;
  logic [32*LANES-1:0]   sum_o;
  logic                  busy_o;
  logic [LANES-1:0]      ovf_o;
  logic                  drop_o;

  int n_pass;
  int n_total;

  psum_accumulator #(.LANES(LANES), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .acc_len_i    (acc_len_i),
    .prod_valid_i (prod_valid_i),
    .prod_i       (prod_i),
    .sum_valid_o  (sum_valid_o),
    .sum_ready_i  (sum_ready_i),
    .sum_o        (sum_o),
    .busy_o       (busy_o),
    .ovf_o        (ovf_o),
    .drop_o       (drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = waiting, 1 = summing, 2 = presenting
  int      m_phase;
  int      m_len;
  int      m_cnt;
  longint  m_acc [LANES];
  logic [LANES-1:0] m_ovf;
  logic    m_drop;
  bit      cmp_en;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_len = 0; m_cnt = 0; m_ovf = '0; m_drop = 1'b0;
      for (int k = 0; k < LANES; k++) m_acc[k] = 0;
    end else begin
      if (m_phase == 0) begin
        if (prod_valid_i) m_drop = 1'b1;
        if (start_i && acc_len_i != 0) begin
          m_len = int'(acc_len_i); m_cnt = 0; m_ovf = '0; m_drop = 1'b0;
          for (int k = 0; k < LANES; k++) m_acc[k] = 0;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (prod_valid_i) begin
          for (int k = 0; k < LANES; k++) begin
            longint s;
            s = m_acc[k] + longint'($signed(prod_i[32*k +: 32]));
            if (s > 64'sd2147483647) begin s = 64'sd2147483647; m_ovf[k] = 1'b1; end
            if (s < -64'sd2147483648) begin s = -64'sd2147483648; m_ovf[k] = 1'b1; end
            m_acc[k] = s;
          end
          m_cnt++;
          if (m_cnt == m_len) m_phase = 2;
        end
      end else begin
        if (prod_valid_i) m_drop = 1'b1;
        if (sum_ready_i) m_phase = 0;
      end
    end
  end

  // Every cycle: control outputs always, lane sums whenever a result is presented.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 64'(busy_o), 64'(m_phase != 0));
      chk("sum_valid", 64'(sum_valid_o), 64'(m_phase == 2));
      chk("ovf", 64'(ovf_o), 64'(m_ovf));
      chk("drop", 64'(drop_o), 64'(m_drop));
      if (m_phase == 2) begin
        for (int k = 0; k < LANES; k++) begin
          logic [31:0] e;
          e = m_acc[k][31:0];
          chk($sformatf("sum_lane%0d", k), 64'(sum_o[32*k +: 32]), 64'(e));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_start(input int len);
    start_i = 1'b1; acc_len_i = LEN_W'(len);
    cyc(1);
    start_i = 1'b0; acc_len_i = '0;
  endtask

  task automatic beat(input logic [32*LANES-1:0] v);
    prod_valid_i = 1'b1; prod_i = v;
    cyc(1);
    prod_valid_i = 1'b0; prod_i = '0;
  endtask

  task automatic take;
    sum_ready_i = 1'b1;
    cyc(1);
    sum_ready_i = 1'b0;
  endtask

  function automatic logic [32*LANES-1:0] all_lanes(input logic [31:0] v);
    return {LANES{v}};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32*LANES-1:0] v;
    n_pass = 0; n_total = 0; cmp_en = 1'b0;
    rst_n = 1'b0; start_i = 1'b0; acc_len_i = '0;
    prod_valid_i = 1'b0; prod_i = '0; sum_ready_i = 1'b0;
    cyc(2);
    chk("rst_sum_valid", 64'(sum_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ovf", 64'(ovf_o), 64'd0);
    chk("rst_drop", 64'(drop_o), 64'd0);
    chk("rst_sum_lo", sum_o[63:0], 64'd0);
    chk("rst_sum_hi", sum_o[32*LANES-1 -: 64], 64'd0);
    cmp_en = 1'b1;
    rst_n = 1'b1;

    // Basic pass: 5 - 2 + 10 = 13, start taken on the first edge after release.
    do_start(3);
    beat(all_lanes(32'd5));
    beat(all_lanes(32'hFFFF_FFFE));
    beat(all_lanes(32'd10));
    chk("basic_latency", 64'(sum_valid_o), 64'd1);
    chk("basic_lane0", 64'(sum_o[31:0]), 64'd13);
    chk("basic_lane15", 64'(sum_o[32*15 +: 32]), 64'd13);
    chk("basic_ovf", 64'(ovf_o), 64'd0);
    take;
    chk("basic_idle", 64'(busy_o), 64'd0);

    // Gapped beats and three cycles of backpressure: 100 - 300 = -200 (0xFFFFFF38).
    do_start(2);
    beat(all_lanes(32'd100));
    cyc(4);
    chk("gap_wait_busy", 64'(busy_o), 64'd1);
    beat(all_lanes(32'hFFFF_FED4));
    for (int i = 0; i < 4; i++) begin
      chk("gap_hold_valid", 64'(sum_valid_o), 64'd1);
      chk("gap_hold_sum", 64'(sum_o[32*7 +: 32]), 64'hFFFF_FF38);
      if (i < 3) cyc(1);
    end
    take;
    chk("gap_released", 64'(sum_valid_o), 64'd0);

    // Saturation on lanes 0 (positive) and 1 (negative).
    do_start(2);
    v = '0; v[31:0] = 32'h7FFF_FFF0; v[63:32] = 32'h8000_0000;
    beat(v);
    v = '0; v[31:0] = 32'h0000_0020; v[63:32] = 32'hFFFF_FFFF;
    beat(v);
    chk("sat_lane0", 64'(sum_o[31:0]), 64'h7FFF_FFFF);
    chk("sat_lane1", 64'(sum_o[63:32]), 64'h8000_0000);
    chk("sat_lane2", 64'(sum_o[95:64]), 64'd0);
    chk("sat_ovf", 64'(ovf_o), 64'h0003);
    take;

    // Beats after a clamp add to the clamped value and the flag stays sticky.
    do_start(3);
    v = '0; v[31:0] = 32'h7FFF_FFFF;
    beat(v);
    v = '0; v[31:0] = 32'h0000_0001;
    beat(v);
    v = '0; v[31:0] = 32'hFFFF_FFFF;
    beat(v);
    chk("sat_resume_lane0", 64'(sum_o[31:0]), 64'h7FFF_FFFE);
    chk("sat_resume_ovf", 64'(ovf_o), 64'h0001);
    take;

    // Drops and ignored starts.
    beat(all_lanes(32'd7));
    chk("drop_idle", 64'(drop_o), 64'd1);
    do_start(2);
    chk("drop_cleared", 64'(drop_o), 64'd0);
    beat(all_lanes(32'd1));
    start_i = 1'b1; acc_len_i = 12'd5;
    beat(all_lanes(32'd2));
    start_i = 1'b0; acc_len_i = '0;
    chk("ign_start_valid", 64'(sum_valid_o), 64'd1);
    beat(all_lanes(32'd99));
    chk("drop_out", 64'(drop_o), 64'd1);
    chk("drop_out_sum", 64'(sum_o[31:0]), 64'd3);
    take;
    do_start(1);
    chk("drop_restart", 64'(drop_o), 64'd0);
    beat(all_lanes(32'd4));
    chk("len1_sum", 64'(sum_o[31:0]), 64'd4);
    take;

    // Zero length is refused and leaves the stray-beat flag alone.
    beat(all_lanes(32'd1));
    do_start(0);
    chk("zero_len_busy", 64'(busy_o), 64'd0);
    chk("zero_len_drop", 64'(drop_o), 64'd1);
    cyc(1);

    // Reset in the middle of a pass, then a fresh one-beat pass.
    do_start(4);
    beat(all_lanes(32'd9));
    #2 rst_n = 1'b0;
    cyc(1);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_valid", 64'(sum_valid_o), 64'd0);
    chk("midrst_sum", sum_o[63:0], 64'd0);
    chk("midrst_drop", 64'(drop_o), 64'd0);
    rst_n = 1'b1;
    do_start(1);
    beat(all_lanes(32'd6));
    chk("postrst_valid", 64'(sum_valid_o), 64'd1);
    chk("postrst_sum", 64'(sum_o[32*3 +: 32]), 64'd6);
    take;
    cyc(2);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 Parameter LANES, default 16: number of product lanes accumulated in parallel.
REQ-002 Parameter LEN_W, default 12: width of the accumulation-length field.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  single-cycle request to begin one accumulation pass.
REQ-006 acc_len_i  input  LEN_W  number of product beats per pass; latched when start_i is accepted.
REQ-007 prod_valid_i  input  1  product beat present on prod_i this cycle.
REQ-008 prod_i  input  32*LANES  signed 32-bit products; lane k at bits [32k+31:32k].
REQ-009 sum_valid_o  output  1  accumulated result available on sum_o.
REQ-010 sum_ready_i  input  1  consumer accepts sum_o this cycle.
REQ-011 sum_o  output  32*LANES  signed 32-bit saturated sums, same lane packing as prod_i.
REQ-012 busy_o  output  1  high in any state other than IDLE.
REQ-013 ovf_o  output  LANES  sticky per-lane saturation flags.
REQ-014 drop_o  output  1  sticky flag: a product beat arrived while not accepted.

Function
REQ-015 The block SHALL implement three states: IDLE, ACC, OUT.
REQ-016 In IDLE, start_i=1 with acc_len_i!=0: latch acc_len_i, clear all lane accumulators, beat counter, ovf_o and drop_o, then go to ACC next cycle.
REQ-017 In IDLE, start_i=1 with acc_len_i=0: no state change; flags not cleared.
REQ-018 start_i in ACC or OUT SHALL be ignored.
REQ-019 In ACC, each cycle with prod_valid_i=1: every lane accumulator gets acc + prod lane, and the beat counter increments.
REQ-020 The beat accepted when counter equals latched length-1 SHALL be the final beat: the state goes to OUT and sum_valid_o rises the next cycle, with sum_o including that beat.
REQ-021 Latency from the final-beat cycle to the sum_valid_o rise SHALL be exactly 1 cycle.
REQ-022 Cycles in ACC with prod_valid_i=0 SHALL leave accumulators and counter unchanged; no timeout.
REQ-023 Accumulation SHALL be signed 33-bit internally with saturation to 32 bits: above 0x7FFFFFFF clamps to 0x7FFFFFFF, below 0x80000000 clamps to 0x80000000.
REQ-024 Any clamp on lane k SHALL set ovf_o[k]; the flag stays set until the next accepted start_i.
REQ-025 Further beats add to the clamped value.
REQ-026 In OUT, sum_valid_o=1 and sum_o SHALL hold stable until sum_valid_o and sum_ready_i are both 1.
REQ-027 On that handshake the state SHALL go to IDLE next cycle and sum_valid_o SHALL fall.
REQ-028 A prod_valid_i=1 beat in IDLE or OUT SHALL be discarded and SHALL set drop_o; accumulators are unchanged.
REQ-029 sum_ready_i outside OUT SHALL have no effect.

Reset
REQ-030 While rst_n=0, the block SHALL be in IDLE, with sum_valid_o=0, sum_o=0, busy_o=0, ovf_o=0, drop_o=0, and the counter and latched length at 0.
REQ-031 Reset asserted mid-pass (ACC or OUT) SHALL abandon the pass immediately with no output beat.
REQ-032 After reset release, the block SHALL accept start_i on the first rising edge.

Verification
REQ-033 Basic pass: start, len=3; all lanes get 5, -2, 10 over back-to-back beats -> sum_valid_o high 1 cycle after the 3rd beat, every lane=13, ovf_o=0.
REQ-034 Gapped input with backpressure: len=2; beats 100 and -300 separated by 4 idle cycles; sum_ready_i low 3 cycles -> sum_o=-200 held stable 4 cycles, then IDLE.
REQ-035 Saturation: len=2; lane 0 gets 0x7FFFFFF0 then 0x20; lane 1 gets 0x80000000 then -1 -> lane0=0x7FFFFFFF, lane1=0x80000000, ovf_o=0x0003.
REQ-036 Drop and ignore: beat in IDLE, start during ACC, extra beat in OUT -> drop_o=1, sum unaffected; next start clears drop_o.
REQ-037 Zero length and reset: start with len=0 -> busy_o stays 0; rst_n pulsed low during ACC after 1 of 4 beats -> all outputs 0, no sum_valid_o; a new len=1 pass then returns the correct sum.
